// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode seven-segment driver.
// Digits are latched into a shadow register once per scan frame so a carry
// rippling through the upstream BCD counters never tears the shown number.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seg7_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     ssd_ctl,
  output logic [7:0]            segs,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW    = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0] ssd_ctl_q, ssd_ctl_d;
  logic [7:0]        segs_q, segs_d;
  logic              frame_start_q, frame_start_d;

  logic              slot_end;
  logic              frame_end;
  logic [3:0]        cur_dig;
  logic              cur_dp;
  logic              cur_blank;
  logic [DIGITS-1:0] blank_vec;

  // BCD nibble to active-low {a,b,c,d,e,f,g}; non-BCD shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  // Scan timing: refresh counter, digit index, frame capture, frame pulse.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    slot_end    = (cnt_q == CNT_LAST);
    frame_end   = slot_end && (idx_q == IDX_LAST);

    if (slot_end) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (frame_end) begin
      shadow_d    = digits_in;
      shadow_dp_d = dp_in;
    end

    // Registered look-ahead so the pulse coincides with the capture cycle.
    frame_start_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  // Per-digit blanking mask (leading zeros above digit 0 when enabled).
  always_comb begin
    blank_vec = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int k = int'(DIGITS) - 1; k > 0; k--) begin
        zero_above   = zero_above && (shadow_q[4*k +: 4] == 4'd0);
        blank_vec[k] = zero_above;
      end
    end
`endif
  end

  // Output decode from the current digit index and shadow contents.
  always_comb begin
    cur_dig   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    ssd_ctl_d = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_dig   = shadow_q[4*k +: 4];
        cur_dp    = shadow_dp_q[k];
        cur_blank = blank_vec[k];
      end
    end
    for (int unsigned k = 0; k < DIGITS; k++) begin
      ssd_ctl_d[k] = ~((idx_q == IDX_W'(k)) && !cur_blank);
    end
    if (cur_blank) begin
      segs_d = 8'hFF;
    end else begin
      segs_d = {decode(cur_dig), ~cur_dp};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      shadow_dp_q   <= '0;
      ssd_ctl_q     <= '1;
      segs_q        <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      shadow_dp_q   <= shadow_dp_d;
      ssd_ctl_q     <= ssd_ctl_d;
      segs_q        <= segs_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ssd_ctl     = ssd_ctl_q;
  assign segs        = segs_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4): cycle-time model plus
// pinned literal expectations, then randomized digits/dp/reset traffic.
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int R     = 4;
  localparam int FRAME = D * R;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  ssd_ctl;
  logic [7:0]  segs;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .ssd_ctl    (ssd_ctl),
    .segs       (segs),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
                               7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};

  logic [3:0] t2_ssd [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] t2_seg [4] = '{8'h99, 8'h0D, 8'h25, 8'h9F};

  // Model: time t since reset; digit shown in cycle t is the one indexed in t-1.
  int          m_t     = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  logic [3:0]  exp_ssd;
  logic [7:0]  exp_segs;
  logic        exp_fs;

  function automatic logic [11:0] model_out(input int cur, input logic [15:0] sh,
                                            input logic [3:0] dp);
    logic [3:0] nib;
    logic       blank;
    nib   = 4'((sh >> (4 * cur)) & 16'hF);
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (cur > 0) && ((sh >> (4 * cur)) == 16'h0);
`endif
    if (blank) return 12'hFFF;
    return {~(4'(1) << cur), seg_tbl[nib], ~dp[cur]};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t      <= 0;
      m_sh     <= '0;
      m_dp     <= '0;
      exp_ssd  <= 4'hF;
      exp_segs <= 8'hFF;
      exp_fs   <= 1'b0;
      m_valid  <= 1'b1;
    end else if (m_valid) begin
      {exp_ssd, exp_segs} <= model_out((m_t / R) % D, m_sh, m_dp);
      if (m_t % FRAME == FRAME - 1) begin
        m_sh <= digits_in;
        m_dp <= dp_in;
      end
      m_t    <= m_t + 1;
      exp_fs <= ((m_t + 1) % FRAME == FRAME - 1);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model t=%0d, time %0t)", name, got, exp, m_t, $time);
    end
  endtask

  // Advance to the next negedge and compare every output against the model.
  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      check("model_ssd_ctl", 32'(ssd_ctl), 32'(exp_ssd));
      check("model_segs", 32'(segs), 32'(exp_segs));
      check("model_frame_start", 32'(frame_start), 32'(exp_fs));
    end
  endtask

  task automatic wait_t(input int n);
    int guard = 0;
    while (m_t != n && guard < 500) begin
      tick();
      guard++;
    end
    if (m_t != n) check("wait_timeout", 32'(m_t), 32'(n));
  endtask

  task automatic pin(input string name, input logic [3:0] e_ssd, input logic [7:0] e_segs);
    check({name, "_ssd"}, 32'(ssd_ctl), 32'(e_ssd));
    check({name, "_segs"}, 32'(segs), 32'(e_segs));
  endtask

  initial begin
    rst_n     = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    repeat (3) tick();
    pin("reset", 4'b1111, 8'hFF);
    check("reset_fs", 32'(frame_start), 32'd0);
    rst_n = 1'b1;

    wait_t(2);
    pin("first_digit", 4'b1110, 8'h03);
    digits_in = 16'h1234;

    wait_t(15);
    check("fs_first", 32'(frame_start), 32'd1);
    wait_t(16);
    check("fs_after", 32'(frame_start), 32'd0);
    for (int t = 17; t <= 32; t++) begin
      wait_t(t);
      pin("frame1234", t2_ssd[(t - 17) / 4], t2_seg[(t - 17) / 4]);
      check("fs_period", 32'(frame_start), 32'(t == 31));
    end

    wait_t(37);
    digits_in = 16'h5678;
    wait_t(41);
    pin("tear_d2", 4'b1011, 8'h25);
    wait_t(45);
    pin("tear_d3", 4'b0111, 8'h9F);
    wait_t(49);
    pin("new_d0", 4'b1110, 8'h01);

    digits_in = 16'hF0A9;
    dp_in     = 4'b0100;
    wait_t(65);
    pin("dash_d0", 4'b1110, 8'h09);
    wait_t(69);
    pin("dash_d1", 4'b1101, 8'hFD);
    wait_t(73);
    pin("dash_d2", 4'b1011, 8'h02);
    wait_t(77);
    pin("dash_d3", 4'b0111, 8'hFD);

    wait_t(90);
    rst_n = 1'b0;
    tick();
    pin("midreset", 4'b1111, 8'hFF);
    check("midreset_fs", 32'(frame_start), 32'd0);
    rst_n = 1'b1;
    dp_in = '0;
    for (int t = 1; t <= 4; t++) begin
      wait_t(t);
      pin("restart_slot", 4'b1110, 8'h03);
    end
    wait_t(5);
    pin("restart_next", 4'b1101, 8'h03);

    digits_in = 16'h0070;
    wait_t(17);
    pin("lz_d0", 4'b1110, 8'h03);
    wait_t(21);
    pin("lz_d1", 4'b1101, 8'h1F);
`ifdef LEADING_ZERO_BLANK_EN
    wait_t(25);
    pin("lz_d2", 4'b1111, 8'hFF);
    wait_t(29);
    pin("lz_d3", 4'b1111, 8'hFF);
`else
    wait_t(25);
    pin("lz_d2", 4'b1011, 8'h03);
    wait_t(29);
    pin("lz_d3", 4'b0111, 8'h03);
`endif
    digits_in = 16'h0000;
    wait_t(33);
    pin("zero_d0", 4'b1110, 8'h03);
`ifdef LEADING_ZERO_BLANK_EN
    wait_t(37);
    pin("zero_d1", 4'b1111, 8'hFF);
`else
    wait_t(37);
    pin("zero_d1", 4'b1101, 8'h03);
`endif

    // Random traffic: nibbles biased toward zero, rare mid-frame resets.
    for (int i = 0; i < 1500; i++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        digits_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      dp_in = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
